fp_accum_seq_32: RTL and testbench

- Initiator side of the 32-bit FP adder's add/ready handshake.
- Accepts a stream of IEEE-754 single-precision words, with a last marker. Folds them into a running sum by issuing one add request per element to an external adder responder, then presents the final sum.
- Sits between a data source and the adder. It handles zero operands locally because the adder assumes a normalised implicit 1.

---
 rtl/fp_accum_seq_32.sv | 220 ++++++++++++++++++++++
 tb/tb_fp_accum_seq_32.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_accum_seq_32.sv
// ---------------------------------------------------------------------------
// fp_accum_seq_32
//
// Folds a stream of IEEE-754 single-precision words into a running sum by
// driving an external adder responder over a level-based add/ready
// handshake. This block never does arithmetic itself. It sequences one add
// request per element and bypasses zero operands locally, because the adder
// assumes a normalised implicit leading 1. If the responder stalls too long,
// the stream is aborted: the rest of the stream is drained and the last good
// sum is reported with an error flag.
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   rst_ni         synchronous active-low reset
//   in_valid_i     source presents an element
//   in_data_i      element word (sign, exp[30:23], frac[22:0])
//   in_last_i      element is the final one of its stream
//   in_ready_o     element is accepted this cycle when in_valid_i is high
//   out_valid_o    final sum is available
//   out_sum_o      accumulated sum
//   out_count_o    number of elements accepted into the sum (saturating)
//   out_err_o      stream was aborted on a responder timeout
//   out_ready_i    sink takes the result
//   add_req_o      add request to the responder
//   add_a_o        operand 1 (accumulator), stable while a request is open
//   add_b_o        operand 2 (incoming element), stable while a request is open
//   add_result_i   responder result
//   add_done_i     responder ready/done level
// ---------------------------------------------------------------------------
module fp_accum_seq_32 #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [31:0]      in_data_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [31:0]      out_sum_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_err_o,
    input  logic             out_ready_i,
    output logic             add_req_o,
    output logic [31:0]      add_a_o,
    output logic [31:0]      add_b_o,
    input  logic [31:0]      add_result_i,
    input  logic             add_done_i
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_CLR,
        S_WAIT_DONE,
        S_RELEASE,
        S_FLUSH,
        S_OUT
    } state_e;

    state_e             state_q,    state_d;
    logic [31:0]        acc_q,      acc_d;
    logic [31:0]        addA_q,     addA_d;
    logic [31:0]        addB_q,     addB_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               lastFlag_q, lastFlag_d;
    logic               err_q,      err_d;
    logic [TMO_W-1:0]   tmo_q,      tmo_d;

    logic               accept;
    logic               elemZero;
    logic               accZero;
    logic [CNT_W-1:0]   countInc;
    logic               tmoHit;

    // A word counts as zero regardless of its sign bit.
    assign accept   = in_valid_i && in_ready_o;
    assign elemZero = (in_data_i[30:0] == 31'd0);
    assign accZero  = (acc_q[30:0] == 31'd0);
    assign countInc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
    assign tmoHit   = (tmo_q == TMO_LAST);

    // State register plus datapath registers, cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            addA_q     <= '0;
            addB_q     <= '0;
            count_q    <= '0;
            lastFlag_q <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            addA_q     <= addA_d;
            addB_q     <= addB_d;
            count_q    <= count_d;
            lastFlag_q <= lastFlag_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        addA_d     = addA_q;
        addB_d     = addB_q;
        count_d    = count_q;
        lastFlag_d = lastFlag_q;
        err_d      = err_q;
        tmo_d      = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d      = in_data_i;
                    count_d    = CNT_W'(1);
                    lastFlag_d = in_last_i;
                    state_d    = in_last_i ? S_OUT : S_FETCH;
                end
            end
            S_FETCH: begin
                if (accept) begin
                    addB_d     = in_data_i;
                    count_d    = countInc;
                    lastFlag_d = in_last_i;
                    // Zero operands never reach the adder: a zero element
                    // leaves the sum alone, a zero sum takes the element as is.
                    if (elemZero) begin
                        state_d = in_last_i ? S_OUT : S_FETCH;
                    end else if (accZero) begin
                        acc_d   = in_data_i;
                        state_d = in_last_i ? S_OUT : S_FETCH;
                    end else begin
                        addA_d  = acc_q;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                // The done level left over from the previous add is stale, so
                // the responder must be seen dropping it before a new result is trusted.
                if (!add_done_i) begin
                    state_d = S_WAIT_DONE;
                end else if (tmoHit) begin
                    err_d   = 1'b1;
                    state_d = lastFlag_q ? S_OUT : S_FLUSH;
                end
            end
            S_WAIT_DONE: begin
                if (add_done_i) begin
                    acc_d   = add_result_i;
                    state_d = S_RELEASE;
                end else if (tmoHit) begin
                    err_d   = 1'b1;
                    state_d = lastFlag_q ? S_OUT : S_FLUSH;
                end
            end
            S_RELEASE: begin
                state_d = lastFlag_q ? S_OUT : S_FETCH;
            end
            S_FLUSH: begin
                if (accept && in_last_i) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    count_d    = '0;
                    lastFlag_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The wait counter restarts on every state entry and only runs while waiting.
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if ((state_q == S_WAIT_CLR) || (state_q == S_WAIT_DONE)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Moore outputs. Gating with rst_ni drops the handshakes the moment reset is applied.
    always_comb begin
        in_ready_o  = 1'b0;
        add_req_o   = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            S_IDLE, S_FETCH, S_FLUSH:         in_ready_o  = rst_ni;
            S_ISSUE, S_WAIT_CLR, S_WAIT_DONE: add_req_o   = rst_ni;
            S_OUT:                            out_valid_o = rst_ni;
            default: ;
        endcase
    end

    assign out_sum_o   = acc_q;
    assign out_count_o = count_q;
    assign out_err_o   = err_q;
    assign add_a_o     = addA_q;
    assign add_b_o     = addB_q;

endmodule

// File: tb/tb_fp_accum_seq_32.sv
// ---------------------------------------------------------------------------
// tb_fp_accum_seq_32
//
// Directed bench for fp_accum_seq_32. A behavioural adder responder with
// configurable latency, a stale-done window and a never-answer mode sits on
// the add handshake. Its results come from a small table of hand-computed
// single-precision sums. A monitor records every add_req pulse: operands at
// issue, high length, low gap and any operand movement while the request is open.
// ---------------------------------------------------------------------------
module tb_fp_accum_seq_32;

    logic        clock = 1'b0;
    logic        rstN;
    logic        inValid;
    logic [31:0] inData;
    logic        inLast;
    logic        inReady;
    logic        outValid;
    logic [31:0] outSum;
    logic [15:0] outCount;
    logic        outErr;
    logic        outReady;
    logic        addReq;
    logic [31:0] addA;
    logic [31:0] addB;
    logic [31:0] addResult = 32'h0;
    logic        addDone   = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    // Responder behaviour, set by the main sequence only.
    int respLatency = 7;
    int respStale   = 0;
    bit respNever   = 1'b0;

    fp_accum_seq_32 #(
        .TIMEOUT (64),
        .CNT_W   (16)
    ) dut (
        .clk_i        (clock),
        .rst_ni       (rstN),
        .in_valid_i   (inValid),
        .in_data_i    (inData),
        .in_last_i    (inLast),
        .in_ready_o   (inReady),
        .out_valid_o  (outValid),
        .out_sum_o    (outSum),
        .out_count_o  (outCount),
        .out_err_o    (outErr),
        .out_ready_i  (outReady),
        .add_req_o    (addReq),
        .add_a_o      (addA),
        .add_b_o      (addB),
        .add_result_i (addResult),
        .add_done_i   (addDone)
    );

    always #5 clock = ~clock;

    // Hand-computed single-precision sums for the operand pairs used below.
    function automatic logic [31:0] refAdd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h3F800000, 32'h3F000000}: return 32'h3FC00000;
            {32'h3FC00000, 32'h3FC00000}: return 32'h40400000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // Responder: keeps its old done level for respStale cycles after a new
    // request, drops it, then raises it with the result respLatency cycles later.
    int respCnt  = 0;
    bit respBusy = 1'b0;
    always @(negedge clock) begin
        if (!addReq) begin
            respBusy = 1'b0;
        end else begin
            if (!respBusy) begin
                respBusy = 1'b1;
                respCnt  = 0;
            end else begin
                respCnt++;
            end
            if (respCnt >= respStale && (respNever || respCnt < respStale + respLatency)) begin
                addDone = 1'b0;
            end else if (respCnt == respStale + respLatency) begin
                addDone   = 1'b1;
                addResult = refAdd(addA, addB);
            end
        end
    end

    // Request monitor, sampled away from the active edge.
    int          reqPulses  = 0;
    int          highLen    = 0;
    int          lastHigh   = 0;
    int          lowLen     = 0;
    int          lastGap    = -1;
    int          moveEvents = 0;
    logic [31:0] pulseA [16];
    logic [31:0] pulseB [16];
    logic [31:0] heldA = 32'h0;
    logic [31:0] heldB = 32'h0;
    logic        prevReq = 1'b0;
    always @(negedge clock) begin
        if (addReq) begin
            if (!prevReq) begin
                if (reqPulses < 16) begin
                    pulseA[reqPulses] = addA;
                    pulseB[reqPulses] = addB;
                end
                if (reqPulses > 0) lastGap = lowLen;
                reqPulses++;
                highLen = 0;
            end else if (addA != heldA || addB != heldB) begin
                moveEvents++;
            end
            heldA = addA;
            heldB = addB;
            highLen++;
        end else begin
            if (prevReq) begin
                lastHigh = highLen;
                lowLen   = 1;
            end else begin
                lowLen++;
            end
        end
        prevReq = addReq;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Presents one element and holds it until the block accepts it.
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        int waitCnt = 0;
        @(negedge clock);
        inValid = 1'b1;
        inData  = data;
        inLast  = last;
        while (!inReady && waitCnt < 500) begin
            @(negedge clock);
            waitCnt++;
        end
        if (waitCnt >= 500) checkOutput("acceptWait", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    // Waits for the result, checks it, then lets the sink take it.
    task automatic waitResult(input string tag, input logic [31:0] expSum,
                              input int expCount, input logic expErr);
        int waitCnt = 0;
        while (!outValid && waitCnt < 500) begin
            @(negedge clock);
            waitCnt++;
        end
        checkOutput({tag, "Valid"}, 32'(outValid), 32'd1);
        checkOutput({tag, "Sum"},   outSum,        expSum);
        if (expCount >= 0) checkOutput({tag, "Count"}, 32'(outCount), 32'(expCount));
        checkOutput({tag, "Err"},   32'(outErr),   32'(expErr));
        outReady = 1'b1;
        @(posedge clock);
        #1;
        outReady = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int basePulses;
        int baseMoves;
        int waitCnt;

        rstN     = 1'b0;
        inValid  = 1'b0;
        inData   = 32'h0;
        inLast   = 1'b0;
        outReady = 1'b0;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rstInReady",  32'(inReady),  32'd0);
        checkOutput("rstOutValid", 32'(outValid), 32'd0);
        checkOutput("rstAddReq",   32'(addReq),   32'd0);
        checkOutput("rstOutErr",   32'(outErr),   32'd0);
        checkOutput("rstCount",    32'(outCount), 32'd0);
        checkOutput("rstSum",      outSum,        32'h0);
        checkOutput("rstAddA",     addA,          32'h0);
        @(negedge clock);
        rstN = 1'b1;
        #1;
        checkOutput("idleInReady", 32'(inReady), 32'd1);

        // Two elements with a 7-cycle responder: one request. It stays high
        // for ISSUE plus the 7 latency cycles, with done captured on the next edge.
        $display("[TB] two-element stream");
        basePulses = reqPulses;
        applyStimulus(32'h3F800000, 1'b0);
        applyStimulus(32'h40000000, 1'b1);
        waitResult("two", 32'h40400000, 2, 1'b0);
        checkOutput("twoPulses",   32'(reqPulses - basePulses), 32'd1);
        checkOutput("twoAddA",     pulseA[basePulses], 32'h3F800000);
        checkOutput("twoAddB",     pulseB[basePulses], 32'h40000000);
        checkOutput("twoHighLen",  32'(lastHigh), 32'd8);

        // Three elements: two requests, the second on the partial sum. Between
        // requests add_req is low through RELEASE and the FETCH accept cycle.
        $display("[TB] three-element stream");
        basePulses = reqPulses;
        baseMoves  = moveEvents;
        applyStimulus(32'h3F800000, 1'b0);
        applyStimulus(32'h3F000000, 1'b0);
        applyStimulus(32'h3FC00000, 1'b1);
        waitResult("three", 32'h40400000, 3, 1'b0);
        checkOutput("threePulses", 32'(reqPulses - basePulses), 32'd2);
        checkOutput("threeAddA1",  pulseA[basePulses + 1], 32'h3FC00000);
        checkOutput("threeAddB1",  pulseB[basePulses + 1], 32'h3FC00000);
        checkOutput("threeGap",    32'(lastGap), 32'd2);
        checkOutput("threeStable", 32'(moveEvents - baseMoves), 32'd0);

        // Stale done: the responder still shows done=1 (result 0x40400000 from
        // the previous add) for 2 cycles into the new request.
        $display("[TB] stale done");
        respStale  = 2;
        basePulses = reqPulses;
        applyStimulus(32'h40000000, 1'b0);
        applyStimulus(32'h40000000, 1'b1);
        waitResult("stale", 32'h40800000, 2, 1'b0);
        checkOutput("stalePulses",  32'(reqPulses - basePulses), 32'd1);
        checkOutput("staleHighLen", 32'(lastHigh), 32'd10);
        respStale = 0;

        // Zero bypass: the adder is never asked.
        $display("[TB] zero bypass");
        basePulses = reqPulses;
        applyStimulus(32'h00000000, 1'b0);
        applyStimulus(32'h80000000, 1'b0);
        applyStimulus(32'h40000000, 1'b1);
        waitResult("zero", 32'h40000000, 3, 1'b0);
        checkOutput("zeroPulses", 32'(reqPulses - basePulses), 32'd0);

        // Timeout: the responder never answers. add_req covers ISSUE, one
        // WAIT_CLR cycle and 64 WAIT_DONE cycles, then the stream is drained.
        $display("[TB] responder timeout");
        respNever  = 1'b1;
        basePulses = reqPulses;
        applyStimulus(32'h3F800000, 1'b0);
        applyStimulus(32'h40000000, 1'b0);
        applyStimulus(32'h41000000, 1'b0);
        applyStimulus(32'h41200000, 1'b1);
        waitResult("tmo", 32'h3F800000, -1, 1'b1);
        checkOutput("tmoPulses",  32'(reqPulses - basePulses), 32'd1);
        checkOutput("tmoHighLen", 32'(lastHigh), 32'd66);
        respNever = 1'b0;

        // Backpressure: result held steady while the sink stalls.
        $display("[TB] backpressure");
        applyStimulus(32'h3F800000, 1'b0);
        applyStimulus(32'h40000000, 1'b1);
        waitCnt = 0;
        while (!outValid && waitCnt < 500) begin
            @(negedge clock);
            waitCnt++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checkOutput("bpValid",   32'(outValid), 32'd1);
            checkOutput("bpSum",     outSum,        32'h40400000);
            checkOutput("bpInReady", 32'(inReady),  32'd0);
        end
        waitResult("bp", 32'h40400000, 2, 1'b0);

        // Reset while waiting on the responder.
        $display("[TB] reset in WAIT_DONE");
        respLatency = 30;
        applyStimulus(32'h3F800000, 1'b0);
        applyStimulus(32'h40000000, 1'b0);
        repeat (5) @(negedge clock);
        checkOutput("preRstAddReq", 32'(addReq), 32'd1);
        rstN = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("midRstAddReq",   32'(addReq),   32'd0);
        checkOutput("midRstOutValid", 32'(outValid), 32'd0);
        checkOutput("midRstInReady",  32'(inReady),  32'd0);
        checkOutput("midRstCount",    32'(outCount), 32'd0);
        checkOutput("midRstAddA",     addA,          32'h0);
        @(negedge clock);
        rstN = 1'b1;
        #1;
        checkOutput("postRstInReady", 32'(inReady), 32'd1);
        checkOutput("postRstAddReq",  32'(addReq),  32'd0);
        respLatency = 7;
        applyStimulus(32'h40000000, 1'b1);
        waitResult("single", 32'h40000000, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
